// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit
// Owns the fetch PC, chooses the next fetch address from the branch
// predictor's IF-stage hint, carries each fetched instruction's prediction
// through IF/ID and ID/EX, and checks it in EX against the resolved outcome.
// A wrong prediction raises redirect/flush in the same cycle and steers the
// fetch PC to the correct address on the next edge. Two saturating counters
// track resolved control-flow instructions and mispredictions.

module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PC_pred_IF,
  input  logic             PC_pred_en_IF,
  input  logic             stall,
  input  logic             hold,
  input  logic [6:0]       opcode_EX,
  input  logic             br_EX,
  input  logic [31:0]      PC_target_EX,
  output logic [31:0]      PC_IF,
  output logic             redirect,
  output logic [31:0]      redirect_PC,
  output logic             flush,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  // RISC-V major opcodes that change control flow
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating increment: sticks at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic             en);
    logic [CNT_W-1:0] result;
    if (en && (value != CNT_MAX)) begin
      result = value + CNT_W'(1);
    end else begin
      result = value;
    end
    return result;
  endfunction

  // IF/ID stage record
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic        ifid_pred_en;
  logic [31:0] ifid_pred_target;

  // ID/EX stage record
  logic        idex_valid;
  logic [31:0] idex_pc;
  logic        idex_pred_en;
  logic [31:0] idex_pred_target;

  // EX-side evaluation
  logic        is_cf;
  logic        actual_taken;
  logic        ex_active;
  logic        mispredict;
  logic [31:0] ex_pc_plus4;
  logic [31:0] actual_next;

  // Fetch-side next address
  logic [31:0] fetch_next;

  // Decode the EX opcode into "is control flow" and the real direction.
  always_comb begin
    is_cf        = 1'b0;
    actual_taken = 1'b0;
    case (opcode_EX)
      OP_BRANCH: begin
        is_cf        = 1'b1;
        actual_taken = br_EX;
      end
      OP_JAL, OP_JALR: begin
        is_cf        = 1'b1;
        actual_taken = 1'b1;
      end
      default: begin
        is_cf        = 1'b0;
        actual_taken = 1'b0;
      end
    endcase
  end

  // Compare the carried prediction with the resolved outcome; an
  // invalid record or a frozen pipeline never mispredicts.
  always_comb begin
    ex_active   = idex_valid & ~hold;
    ex_pc_plus4 = idex_pc + 32'd4;
    mispredict  = 1'b0;
    if (actual_taken) begin
      actual_next = PC_target_EX;
    end else begin
      actual_next = ex_pc_plus4;
    end
    if (ex_active) begin
      mispredict = (idex_pred_en != actual_taken) |
                   (idex_pred_en & actual_taken &
                    (idex_pred_target != PC_target_EX));
    end else begin
      mispredict = 1'b0;
    end
  end

  // Drive the redirect interface; redirect_PC is zero when idle.
  always_comb begin
    redirect = mispredict;
    flush    = mispredict;
    if (mispredict) begin
      redirect_PC = actual_next;
    end else begin
      redirect_PC = 32'h0000_0000;
    end
  end

  // Sequential fetch address: follow the prediction or fall through by 4.
  always_comb begin
    if (PC_pred_en_IF) begin
      fetch_next = PC_pred_IF;
    end else begin
      fetch_next = PC_IF + 32'd4;
    end
  end

  // Fetch PC and stage records: hold > redirect > stall > advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC_IF            <= RESET_PC;
      ifid_valid       <= 1'b0;
      ifid_pc          <= 32'h0000_0000;
      ifid_pred_en     <= 1'b0;
      ifid_pred_target <= 32'h0000_0000;
      idex_valid       <= 1'b0;
      idex_pc          <= 32'h0000_0000;
      idex_pred_en     <= 1'b0;
      idex_pred_target <= 32'h0000_0000;
    end else if (hold) begin
      PC_IF      <= PC_IF;
      ifid_valid <= ifid_valid;
      idex_valid <= idex_valid;
    end else if (mispredict) begin
      PC_IF      <= redirect_PC;
      ifid_valid <= 1'b0;
      idex_valid <= 1'b0;
    end else if (stall) begin
      PC_IF      <= PC_IF;
      ifid_valid <= ifid_valid;
      idex_valid <= 1'b0;
    end else begin
      PC_IF            <= fetch_next;
      ifid_valid       <= 1'b1;
      ifid_pc          <= PC_IF;
      ifid_pred_en     <= PC_pred_en_IF;
      ifid_pred_target <= PC_pred_IF;
      idex_valid       <= ifid_valid;
      idex_pc          <= ifid_pc;
      idex_pred_en     <= ifid_pred_en;
      idex_pred_target <= ifid_pred_target;
    end
  end

  // Performance counters: count resolved control flow and mispredicts,
  // frozen while the pipeline is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else if (hold) begin
      br_cnt      <= br_cnt;
      mispred_cnt <= mispred_cnt;
    end else begin
      br_cnt      <= sat_inc(br_cnt, ex_active & is_cf);
      mispred_cnt <= sat_inc(mispred_cnt, mispredict);
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed, table-driven bench for pc_redirect_unit (CNT_W=4 so that
// counter saturation is reachable in a short run).

module tb_pc_redirect_unit;

  localparam logic [6:0] NOP  = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_pred_IF;
  logic        PC_pred_en_IF;
  logic        stall;
  logic        hold;
  logic [6:0]  opcode_EX;
  logic        br_EX;
  logic [31:0] PC_target_EX;
  logic [31:0] PC_IF;
  logic        redirect;
  logic [31:0] redirect_PC;
  logic        flush;
  logic [3:0]  br_cnt;
  logic [3:0]  mispred_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        stall;
    logic        hold;
    logic        pen;
    logic [31:0] ptgt;
    logic [6:0]  op;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic        e_red;
    logic [31:0] e_rpc;
    logic [3:0]  e_br;
    logic [3:0]  e_mis;
  } vec_t;

  vec_t tbl [32];

  pc_redirect_unit #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PC_pred_IF    (PC_pred_IF),
    .PC_pred_en_IF (PC_pred_en_IF),
    .stall         (stall),
    .hold          (hold),
    .opcode_EX     (opcode_EX),
    .br_EX         (br_EX),
    .PC_target_EX  (PC_target_EX),
    .PC_IF         (PC_IF),
    .redirect      (redirect),
    .redirect_PC   (redirect_PC),
    .flush         (flush),
    .br_cnt        (br_cnt),
    .mispred_cnt   (mispred_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int s, input int h, input int pen,
                              input logic [31:0] ptgt, input logic [6:0] op,
                              input int br, input logic [31:0] tgt,
                              input logic [31:0] epc, input int ered,
                              input logic [31:0] erpc, input int ebr,
                              input int emis);
    vec_t v;
    v.stall = (s != 0);
    v.hold  = (h != 0);
    v.pen   = (pen != 0);
    v.ptgt  = ptgt;
    v.op    = op;
    v.br    = (br != 0);
    v.tgt   = tgt;
    v.e_pc  = epc;
    v.e_red = (ered != 0);
    v.e_rpc = erpc;
    v.e_br  = 4'(ebr);
    v.e_mis = 4'(emis);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive inputs, check the pre-edge view, then step
  // to the next negedge (one rising edge in between).
  task automatic apply(input vec_t v, input string tag);
    stall         = v.stall;
    hold          = v.hold;
    PC_pred_en_IF = v.pen;
    PC_pred_IF    = v.ptgt;
    opcode_EX     = v.op;
    br_EX         = v.br;
    PC_target_EX  = v.tgt;
    #1;
    chk({tag, ".pc"},       PC_IF,              v.e_pc);
    chk({tag, ".redirect"}, 32'(redirect),      32'(v.e_red));
    chk({tag, ".flush"},    32'(flush),         32'(v.e_red));
    chk({tag, ".rpc"},      redirect_PC,        v.e_rpc);
    chk({tag, ".br_cnt"},   32'(br_cnt),        32'(v.e_br));
    chk({tag, ".mis_cnt"},  32'(mispred_cnt),   32'(v.e_mis));
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] p;
    int br_e;
    int mis_e;

    // stall hold pen ptgt op br tgt | pc red rpc br mis
    tbl[0]  = mk(0,0,0,32'h0,  NOP, 0,32'h0,       32'h0,  0,32'h0,  0,0);
    tbl[1]  = mk(0,0,0,32'h0,  NOP, 0,32'h0,       32'h4,  0,32'h0,  0,0);
    tbl[2]  = mk(0,0,0,32'h0,  NOP, 0,32'h0,       32'h8,  0,32'h0,  0,0);
    tbl[3]  = mk(0,0,0,32'h0,  NOP, 0,32'h0,       32'hC,  0,32'h0,  0,0);
    tbl[4]  = mk(0,0,1,32'h40, NOP, 0,32'h0,       32'h10, 0,32'h0,  0,0);
    tbl[5]  = mk(0,0,0,32'h0,  NOP, 0,32'h0,       32'h40, 0,32'h0,  0,0);
    tbl[6]  = mk(0,0,0,32'h0,  BR,  1,32'h40,      32'h44, 0,32'h0,  0,0);
    tbl[7]  = mk(0,0,1,32'h10, NOP, 0,32'h0,       32'h48, 0,32'h0,  1,0);
    tbl[8]  = mk(0,0,1,32'h40, NOP, 0,32'h0,       32'h10, 0,32'h0,  1,0);
    tbl[9]  = mk(0,0,0,32'h0,  JAL, 0,32'h10,      32'h40, 0,32'h0,  1,0);
    tbl[10] = mk(0,0,0,32'h0,  BR,  0,32'h40,      32'h44, 1,32'h14, 2,0);
    tbl[11] = mk(0,0,0,32'h0,  BR,  0,32'h40,      32'h14, 0,32'h0,  3,1);
    tbl[12] = mk(0,0,1,32'h80, BR,  0,32'h40,      32'h18, 0,32'h0,  3,1);
    tbl[13] = mk(0,0,0,32'h0,  NOP, 0,32'h0,       32'h80, 0,32'h0,  3,1);
    tbl[14] = mk(0,0,0,32'h0,  JALR,0,32'h90,      32'h84, 1,32'h90, 3,1);
    tbl[15] = mk(0,0,1,32'h20, NOP, 0,32'h0,       32'h90, 0,32'h0,  4,2);
    tbl[16] = mk(0,0,1,32'h60, NOP, 0,32'h0,       32'h20, 0,32'h0,  4,2);
    tbl[17] = mk(0,0,0,32'h0,  JAL, 0,32'h20,      32'h60, 0,32'h0,  4,2);
    tbl[18] = mk(0,0,0,32'h0,  NOP, 0,32'h60,      32'h64, 1,32'h24, 5,2);
    tbl[19] = mk(0,0,0,32'h0,  NOP, 0,32'h0,       32'h24, 0,32'h0,  5,3);
    tbl[20] = mk(1,0,0,32'h0,  NOP, 0,32'h0,       32'h28, 0,32'h0,  5,3);
    tbl[21] = mk(1,0,0,32'h0,  NOP, 0,32'h0,       32'h28, 0,32'h0,  5,3);
    tbl[22] = mk(0,0,0,32'h0,  JAL, 0,32'hDEAD0000,32'h28, 0,32'h0,  5,3);
    tbl[23] = mk(0,0,1,32'h100,NOP, 0,32'h0,       32'h2C, 0,32'h0,  5,3);
    tbl[24] = mk(0,0,0,32'h0,  NOP, 0,32'h0,       32'h100,0,32'h0,  5,3);
    tbl[25] = mk(1,0,0,32'h0,  BR,  0,32'h100,     32'h104,1,32'h30, 5,3);
    tbl[26] = mk(0,0,1,32'h200,NOP, 0,32'h0,       32'h30, 0,32'h0,  6,4);
    tbl[27] = mk(0,0,0,32'h0,  NOP, 0,32'h0,       32'h200,0,32'h0,  6,4);
    tbl[28] = mk(0,1,0,32'h0,  JAL, 0,32'h300,     32'h204,0,32'h0,  6,4);
    tbl[29] = mk(0,1,0,32'h0,  JAL, 0,32'h300,     32'h204,0,32'h0,  6,4);
    tbl[30] = mk(0,0,0,32'h0,  JAL, 0,32'h300,     32'h204,1,32'h300,6,4);
    tbl[31] = mk(0,0,0,32'h0,  NOP, 0,32'h0,       32'h300,0,32'h0,  7,5);

    rst           = 1'b1;
    stall         = 1'b0;
    hold          = 1'b0;
    PC_pred_en_IF = 1'b0;
    PC_pred_IF    = 32'h0;
    opcode_EX     = NOP;
    br_EX         = 1'b0;
    PC_target_EX  = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset.pc",       PC_IF,             32'h0);
    chk("reset.redirect", 32'(redirect),     32'h0);
    chk("reset.flush",    32'(flush),        32'h0);
    chk("reset.rpc",      redirect_PC,       32'h0);
    chk("reset.br_cnt",   32'(br_cnt),       32'h0);
    chk("reset.mis_cnt",  32'(mispred_cnt),  32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Main directed table
    for (int i = 0; i < 32; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Counter saturation: each round issues a JALR with a wrong predicted
    // target, bumping both counters.
    p     = 32'h304;
    br_e  = 7;
    mis_e = 5;
    for (int i = 0; i < 12; i++) begin
      apply(mk(0,0,1,p + 32'h100,NOP,0,32'h0, p,0,32'h0,br_e,mis_e), "satA");
      apply(mk(0,0,0,32'h0,NOP,0,32'h0, p + 32'h100,0,32'h0,br_e,mis_e), "satB");
      apply(mk(0,0,0,32'h0,JALR,0,p + 32'h200, p + 32'h104,1,p + 32'h200,br_e,mis_e), "satC");
      if (br_e < 15) br_e++;
      if (mis_e < 15) mis_e++;
      p = p + 32'h200;
    end
    chk("sat.br_final",  32'(br_cnt),      32'hF);
    chk("sat.mis_final", 32'(mispred_cnt), 32'hF);

    // Address wrap: fetch PC+4 and redirect pc+4 both wrap to zero.
    apply(mk(0,0,1,32'hFFFF_FFFC,NOP,0,32'h0,        p,            0,32'h0,15,15), "wrapX");
    apply(mk(0,0,1,32'h500,      NOP,0,32'h0,        32'hFFFF_FFFC,0,32'h0,15,15), "wrapY");
    apply(mk(0,0,0,32'h0,        JAL,0,32'hFFFF_FFFC,32'h500,      0,32'h0,15,15), "wrapZ");
    apply(mk(0,0,0,32'h0,        BR, 0,32'h777,      32'h504,      1,32'h0,15,15), "wrapW");
    apply(mk(0,0,1,32'hFFFF_FFFC,NOP,0,32'h0,        32'h0,        0,32'h0,15,15), "wrapV");
    apply(mk(0,0,0,32'h0,        NOP,0,32'h0,        32'hFFFF_FFFC,0,32'h0,15,15), "wrapT");
    apply(mk(0,0,0,32'h0,        JAL,0,32'hFFFF_FFFC,32'h0,        0,32'h0,15,15), "wrapS");
    apply(mk(0,0,0,32'h0,        NOP,0,32'h0,        32'h4,        0,32'h0,15,15), "wrapR");

    // Mid-stream asynchronous reset while a would-be mispredict sits in EX
    opcode_EX    = JAL;
    br_EX        = 1'b0;
    PC_target_EX = 32'h999;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.pc",       PC_IF,            32'h0);
    chk("midrst.redirect", 32'(redirect),    32'h0);
    chk("midrst.br_cnt",   32'(br_cnt),      32'h0);
    chk("midrst.mis_cnt",  32'(mispred_cnt), 32'h0);
    @(negedge clk);
    #1;
    chk("midrst.pc_held",  PC_IF,            32'h0);
    rst = 1'b0;
    apply(mk(0,0,0,32'h0,JAL,0,32'h999, 32'h0,0,32'h0,0,0), "rstA");
    apply(mk(0,0,0,32'h0,JAL,0,32'h999, 32'h4,0,32'h0,0,0), "rstB");
    apply(mk(0,0,0,32'h0,NOP,0,32'h0,   32'h8,0,32'h0,0,0), "rstC");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
